// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N requesters, the arbitrated mux and its consumer.
// slave is the arbiter's view; master is the view of the surrounding requesters/consumer.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 16
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               fix_en;
  logic [SELW-1:0]    fix_sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;

  modport slave (
    input  in_valid, in_data, fix_en, fix_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, fix_en, fix_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-way round-robin (or fixed-select) arbitrated mux into one output register; 1-cycle latency.
// Output holds while out_ready=0 and all in_ready drop; drain and refill share a cycle.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arb_mux_if.slave  bus
);
  localparam int SELW = $clog2(N);
  localparam int PW   = 1 << SELW;
  localparam logic [SELW:0]   N_W   = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic             load_en;
  logic             take;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [SELW:0]    scan_idx;
  logic [PW-1:0]    valid_ext;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !out_valid_q | bus.out_ready;
  assign take    = !rst & load_en & grant_vld;

  // Padding to a power of two makes an out-of-range fix_sel read as "not valid".
  always_comb begin
    valid_ext = PW'(bus.in_valid);
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (bus.fix_en) begin
      grant_vld = valid_ext[bus.fix_sel];
      grant_idx = bus.fix_sel;
    end else begin
      // Scan downward so the closest channel at or after rr_ptr wins last.
      for (int k = N - 1; k >= 0; k--) begin
        scan_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (scan_idx >= N_W) scan_idx = scan_idx - N_W;
        if (valid_ext[scan_idx[SELW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_data   = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data      = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = take;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = take;
      if (take) begin
        out_data_d = grant_data;
        out_sel_d  = grant_idx;
        rr_ptr_d   = (grant_idx == LAST) ? '0 : grant_idx + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: stimulus queues expected words, a monitor pops them on each output transfer.
module tb_rr_arb_mux;
  localparam int W = 32;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(W), .N(16)) b16();
  rr_arb_mux_if #(.WIDTH(W), .N(12)) b12();

  rr_arb_mux #(.WIDTH(W), .N(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  rr_arb_mux #(.WIDTH(W), .N(12)) dut12 (.clk(clk), .rst(rst), .bus(b12));

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq3[9]  = '{3, 9, 3, 9, 3, 9, 3, 3, 3};

  function automatic logic [31:0] tag(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    exp_t e;
    e.sel = 4'(ch);
    e.dat = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && b16.out_valid === 1'b1 && b16.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got sel %0d data %h, required no output", b16.out_sel, b16.out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_sel", 64'(b16.out_sel), 64'(mon_e.sel));
        chk("sb_data", 64'(b16.out_data), 64'(mon_e.dat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    b16.in_valid  = '1;
    b16.fix_en    = 1'b0;
    b16.fix_sel   = '0;
    b16.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) b16.in_data[i*W +: W] = tag(i);
    b12.in_valid  = '1;
    b12.fix_en    = 1'b0;
    b12.fix_sel   = '0;
    b12.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) b12.in_data[i*W +: W] = tag(i);

    // Reset held for two edges with every channel requesting.
    for (int r = 0; r < 2; r++) begin
      step();
      @(negedge clk);
      chk("rst_in_ready", 64'(b16.in_ready), 64'h0);
      chk("rst_out_valid", 64'(b16.out_valid), 64'h0);
      chk("rst_out_data", 64'(b16.out_data), 64'h0);
      chk("rst_in_ready12", 64'(b12.in_ready), 64'h0);
    end
    step();
    rst = 1'b0;
    b12.in_valid = '0;

    // Full round-robin sweep with wrap, one word per cycle.
    for (int k = 0; k < 17; k++) push(k % 16, tag(k % 16));
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk("rr_in_ready", 64'(b16.in_ready), 64'(1) << (k % 16));
      if (k > 0) chk("rr_no_bubble", 64'(b16.out_valid), 64'h1);
      step();
    end
    b16.in_valid = '0;
    step();
    step();

    // Sparse requesters 3 and 9, then 9 drops out.
    b16.in_valid = 16'h0208;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) b16.in_valid = 16'h0008;
      push(seq3[k], tag(seq3[k]));
      @(negedge clk);
      chk("sparse_in_ready", 64'(b16.in_ready), 64'(1) << seq3[k]);
      step();
    end
    b16.in_valid = '0;
    step();
    step();

    // Backpressure on a held word from channel 5.
    b16.in_data[5*W +: W] = 32'hDEAD_BEEF;
    b16.in_valid = 16'h0020;
    push(5, 32'hDEAD_BEEF);
    push(5, 32'h5555_0005);
    @(negedge clk);
    chk("bp_grant", 64'(b16.in_ready), 64'h20);
    step();
    b16.out_ready = 1'b0;
    b16.in_data[5*W +: W] = 32'h5555_0005;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(b16.out_valid), 64'h1);
      chk("bp_hold_data", 64'(b16.out_data), 64'hDEAD_BEEF);
      chk("bp_hold_sel", 64'(b16.out_sel), 64'h5);
      chk("bp_hold_in_ready", 64'(b16.in_ready), 64'h0);
      step();
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(b16.in_ready), 64'h20);
    step();
    b16.in_valid = '0;
    @(negedge clk);
    chk("bp_next_data", 64'(b16.out_data), 64'h5555_0005);
    step();
    step();
    b16.in_data[5*W +: W] = tag(5);

    // Fixed-select mode; the N=12 instance points past its last channel.
    b16.fix_en   = 1'b1;
    b16.fix_sel  = 4'd7;
    b16.in_valid = '1;
    b12.fix_en   = 1'b1;
    b12.fix_sel  = 4'd15;
    b12.in_valid = '1;
    for (int k = 0; k < 4; k++) begin
      push(7, tag(7));
      @(negedge clk);
      chk("fix_in_ready", 64'(b16.in_ready), 64'h80);
      chk("fix12_oob_in_ready", 64'(b12.in_ready), 64'h0);
      chk("fix12_oob_out_valid", 64'(b12.out_valid), 64'h0);
      step();
    end
    b16.in_valid = 16'hFF7F;
    b12.fix_sel  = 4'd11;
    @(negedge clk);
    chk("fix_drop_in_ready", 64'(b16.in_ready), 64'h0);
    chk("fix12_last_in_ready", 64'(b12.in_ready), 64'h800);
    step();
    b12.in_valid = '0;
    @(negedge clk);
    chk("fix_drop_out_valid", 64'(b16.out_valid), 64'h0);
    chk("fix_drop_in_ready2", 64'(b16.in_ready), 64'h0);
    chk("fix12_out_valid", 64'(b12.out_valid), 64'h1);
    chk("fix12_out_sel", 64'(b12.out_sel), 64'd11);
    chk("fix12_out_data", 64'(b12.out_data), 64'(tag(11)));
    step();

    // Back to round-robin: pointer advanced past 7 during fixed mode.
    b16.fix_en   = 1'b0;
    b16.in_valid = '1;
    @(negedge clk);
    chk("mode_toggle_in_ready", 64'(b16.in_ready), 64'h100);
    step();
    b16.out_ready = 1'b0;
    @(negedge clk);
    chk("rm_held_valid", 64'(b16.out_valid), 64'h1);
    chk("rm_held_sel", 64'(b16.out_sel), 64'd8);
    chk("rm_held_data", 64'(b16.out_data), 64'(tag(8)));
    chk("rm_held_in_ready", 64'(b16.in_ready), 64'h0);
    step();

    // Reset while a word is stalled in the output register.
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_in_ready", 64'(b16.in_ready), 64'h0);
    step();
    rst = 1'b0;
    b16.out_ready = 1'b1;
    push(0, tag(0));
    @(negedge clk);
    chk("rm_valid_cleared", 64'(b16.out_valid), 64'h0);
    chk("rm_data_cleared", 64'(b16.out_data), 64'h0);
    chk("rm_first_grant", 64'(b16.in_ready), 64'h1);
    step();
    push(1, tag(1));
    @(negedge clk);
    chk("rm_second_grant", 64'(b16.in_ready), 64'h2);
    step();
    b16.in_valid = '0;
    step();
    step();

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
